// File: rtl/debounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_scan_ctrl
//  Purpose  : Time-multiplexed debouncer for a bank of N_CH switches.
//             A shared prescaler issues one sample tick every TICK_DIV clocks.
//             On each tick a scan FSM visits every channel, one per clock.
//             Each visit updates a small per-channel stability counter.
//             A new level is accepted once STABLE_CNT consecutive samples
//             differ from the current debounced level.
//  Ports    : clk        - system clock
//             reset      - synchronous, active-high reset
//             sw         - raw asynchronous switch inputs [N_CH]
//             enable     - 1 = prescaler runs, 0 = prescaler holds its value
//             db_level   - registered debounced level per channel
//             db_rise    - one-clock pulse when db_level[i] goes 0->1
//             db_fall    - one-clock pulse when db_level[i] goes 1->0
//             scan_busy  - high while the FSM is scanning channels
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_scan_ctrl #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw,
    input  logic            enable,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] db_rise,
    output logic [N_CH-1:0] db_fall,
    output logic            scan_busy
);

    localparam int c_cnt_w = $clog2(STABLE_CNT + 1);
    localparam int c_idx_w = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_pre_w = $clog2(TICK_DIV);

    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_DIV - 1);
    localparam logic [c_pre_w-1:0] c_pre_one  = c_pre_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N_CH - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(STABLE_CNT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [N_CH-1:0]      r_sync1;
    logic [N_CH-1:0]      r_sw_s;
    logic [c_pre_w-1:0]   r_presc;
    logic                 w_tick;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_cnt_w-1:0]   r_cnt [N_CH];

    logic                 w_cur_sw;
    logic                 w_cur_lvl;
    logic [c_cnt_w-1:0]   w_cur_cnt;
    logic                 w_idx_last;

    // ------------------------------------------------------------------
    // Two-flop synchronizer; only r_sw_s is used downstream.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sw_s  <= '0;
        end else begin
            r_sync1 <= sw;
            r_sw_s  <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Shared prescaler. It freezes (not clears) when enable is low, so
    // the tick phase resumes where it left off.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else if (enable) begin
            if (r_presc == c_pre_last) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + c_pre_one;
            end
        end
    end

    assign w_tick = (r_presc == c_pre_last) && enable;

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_idx_last = (r_idx == c_idx_last);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // A scan always finishes, even if enable drops meanwhile.
                if (w_idx_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign scan_busy = (r_state == ST_SCAN);

    // ------------------------------------------------------------------
    // Per-channel datapath for the channel currently being visited.
    // ------------------------------------------------------------------
    assign w_cur_sw  = r_sw_s[r_idx];
    assign w_cur_lvl = db_level[r_idx];
    assign w_cur_cnt = r_cnt[r_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx    <= '0;
            db_level <= '0;
            db_rise  <= '0;
            db_fall  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            // Edge pulses last a single clock unless re-armed below.
            db_rise <= '0;
            db_fall <= '0;

            if (r_state == ST_SCAN) begin
                if (w_cur_sw == w_cur_lvl) begin
                    // Input fell back to the accepted level: a glitch.
                    r_cnt[r_idx] <= '0;
                end else if (w_cur_cnt == c_cnt_max) begin
                    db_level[r_idx] <= w_cur_sw;
                    r_cnt[r_idx]    <= '0;
                    if (w_cur_sw) begin
                        db_rise[r_idx] <= 1'b1;
                    end else begin
                        db_fall[r_idx] <= 1'b1;
                    end
                end else begin
                    r_cnt[r_idx] <= w_cur_cnt + c_cnt_one;
                end

                if (!w_idx_last) begin
                    r_idx <= r_idx + c_idx_one;
                end
            end else if (w_tick) begin
                r_idx <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debounce_scan_ctrl
//  Purpose  : Directed self-checking bench for debounce_scan_ctrl with
//             N_CH=4, TICK_DIV=8, STABLE_CNT=3. Expected values are
//             hand-derived against an absolute cycle count E<n>, where E1 is
//             the first clock edge after reset is released. Scans start at
//             every E = 8*m. Channel i is visited in the cycle after E+i, so
//             its result is visible after edge E+i+1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_scan_ctrl;

    localparam int N_CH       = 4;
    localparam int TICK_DIV   = 8;
    localparam int STABLE_CNT = 3;

    logic            clk;
    logic            reset;
    logic [N_CH-1:0] sw;
    logic            enable;
    logic [N_CH-1:0] db_level;
    logic [N_CH-1:0] db_rise;
    logic [N_CH-1:0] db_fall;
    logic            scan_busy;

    debounce_scan_ctrl #(
        .N_CH       (N_CH),
        .TICK_DIV   (TICK_DIV),
        .STABLE_CNT (STABLE_CNT)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .enable    (enable),
        .db_level  (db_level),
        .db_rise   (db_rise),
        .db_fall   (db_fall),
        .scan_busy (scan_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc  = 0;
    int base = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    int rise_total = 0;
    int fall_total = 0;
    int multi_hot  = 0;

    // Pulse monitor: counts every pulse bit and any clock with more than one.
    always @(negedge clk) begin
        if (!reset) begin
            rise_total = rise_total + $countones(db_rise);
            fall_total = fall_total + $countones(db_fall);
            if ($countones({db_rise, db_fall}) > 1) multi_hot = multi_hot + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (E%0d)", tag, act, exp, cyc - base);
        end
    endtask

    // Advance to 1 time unit after edge E<c>.
    task automatic goto(input int c);
        while (cyc < base + c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int busy_cnt;
    int first_busy;

    initial begin
        reset  = 1'b1;
        sw     = '0;
        enable = 1'b1;
        base   = 0;
        goto(4);
        check("reset_level", 32'(db_level), 32'h0);
        check("reset_rise",  32'(db_rise),  32'h0);
        check("reset_fall",  32'(db_fall),  32'h0);
        check("reset_busy",  32'(scan_busy), 32'h0);
        reset = 1'b0;
        base  = 4;

        // Test 1: idle input, busy pattern 4 of every 8 cycles.
        busy_cnt   = 0;
        first_busy = -1;
        for (int c = 1; c <= 100; c++) begin
            goto(c);
            if (scan_busy) begin
                busy_cnt = busy_cnt + 1;
                if (first_busy < 0) first_busy = c;
            end
        end
        check("t1_first_busy", 32'(first_busy), 32'd8);
        check("t1_busy_cnt",   32'(busy_cnt),   32'd48);
        check("t1_level",      32'(db_level),   32'h0);
        check("t1_pulses",     32'(rise_total + fall_total), 32'd0);

        // Test 2: ch1 rises; sw_s valid after E111, accepted at E130.
        goto(109);
        sw = 4'b0010;
        goto(129);
        check("t2_level_pre", 32'(db_level), 32'h0);
        goto(130);
        check("t2_level", 32'(db_level), 32'h2);
        check("t2_rise",  32'(db_rise),  32'h2);
        check("t2_fall",  32'(db_fall),  32'h0);
        goto(131);
        check("t2_rise_end", 32'(db_rise), 32'h0);

        // Test 3: ch2 toggles every 5 cycles; never 3 differing samples.
        for (int k = 0; k < 12; k++) begin
            goto(139 + 5 * k);
            sw[2] = ~sw[2];
        end
        goto(220);
        check("t3_level",  32'(db_level),   32'h2);
        check("t3_rises",  32'(rise_total), 32'd1);
        check("t3_falls",  32'(fall_total), 32'd0);

        // Test 4: ch1 falls; sw_s valid after E225, accepted at E242.
        goto(223);
        sw = 4'b0000;
        goto(241);
        check("t4_level_pre", 32'(db_level), 32'h2);
        goto(242);
        check("t4_level", 32'(db_level), 32'h0);
        check("t4_fall",  32'(db_fall),  32'h2);
        goto(243);
        check("t4_fall_end", 32'(db_fall), 32'h0);

        // Test 5: ch0 and ch3 together; accepted at E265 and E268.
        sw = 4'b1001;
        goto(264);
        check("t5_level_pre", 32'(db_level), 32'h0);
        goto(265);
        check("t5_rise0",  32'(db_rise),  32'h1);
        check("t5_level0", 32'(db_level), 32'h1);
        goto(266);
        check("t5_gap1", 32'(db_rise), 32'h0);
        goto(267);
        check("t5_gap2", 32'(db_rise), 32'h0);
        goto(268);
        check("t5_rise3",  32'(db_rise),  32'h8);
        check("t5_level3", 32'(db_level), 32'h9);
        goto(269);
        check("t5_level_final", 32'(db_level), 32'h9);

        // Test 6: ch0 counts to 2 (scans 280, 288); reset during scan 296.
        goto(275);
        sw = 4'b0000;
        goto(296);
        check("t6_busy_before", 32'(scan_busy), 32'h1);
        reset = 1'b1;
        goto(297);
        check("t6_level", 32'(db_level),  32'h0);
        check("t6_rise",  32'(db_rise),   32'h0);
        check("t6_fall",  32'(db_fall),   32'h0);
        check("t6_busy",  32'(scan_busy), 32'h0);
        goto(298);
        reset = 1'b0;
        // New schedule: scans at 306, 314, 322, 330, ...
        goto(299);
        sw = 4'b0001;
        goto(307);
        check("t6_no_stale_count", 32'(db_level), 32'h0);
        goto(322);
        check("t6_level_pre", 32'(db_level), 32'h0);
        goto(323);
        check("t6_level_set", 32'(db_level), 32'h1);
        check("t6_rise_set",  32'(db_rise),  32'h1);
        goto(324);
        check("t6_rise_end", 32'(db_rise), 32'h0);

        // Test 7: enable drops mid-scan; prescaler holds at 1.
        goto(330);
        check("t7_busy_scan", 32'(scan_busy), 32'h1);
        goto(331);
        enable = 1'b0;
        goto(333);
        check("t7_busy_finish", 32'(scan_busy), 32'h1);
        goto(334);
        check("t7_busy_drop", 32'(scan_busy), 32'h0);
        busy_cnt = 0;
        for (int c = 335; c <= 359; c++) begin
            goto(c);
            if (scan_busy) busy_cnt = busy_cnt + 1;
        end
        check("t7_no_scan_disabled", 32'(busy_cnt), 32'd0);
        enable = 1'b1;
        goto(365);
        check("t7_resume_wait", 32'(scan_busy), 32'h0);
        goto(366);
        check("t7_resume_scan", 32'(scan_busy), 32'h1);
        goto(369);
        check("t7_resume_last", 32'(scan_busy), 32'h1);
        goto(370);
        check("t7_resume_done", 32'(scan_busy), 32'h0);

        // Totals over the whole run.
        check("total_rises", 32'(rise_total), 32'd4);
        check("total_falls", 32'(fall_total), 32'd1);
        check("multi_hot",   32'(multi_hot),  32'd0);
        check("final_level", 32'(db_level),   32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
